// File: rtl/approx_adder_sweep_ctrl.sv
// rtl/approx_adder_sweep_ctrl.sv - exhaustive input sweep and error statistics for an approximate adder
// Drives every {b, a} vector on pi, waits SETTLE cycles, then grades po against the exact sum.
module approx_adder_sweep_ctrl #(
  parameter int OP_W   = 2,
  parameter int OUT_W  = 3,
  parameter int WCE    = 2,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [2*OP_W-1:0]   pi,
  input  logic [OUT_W-1:0]    po,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [OUT_W-1:0]    max_err,
  output logic [2*OP_W:0]     err_cnt,
  output logic [2*OP_W:0]     viol_cnt,
  output logic [2*OP_W-1:0]   first_viol
);

  localparam int PI_W  = 2 * OP_W;
  localparam int CNT_W = PI_W + 1;
  localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [SC_W-1:0]  SETTLE_V = SC_W'(SETTLE);
  localparam logic [OUT_W-1:0] WCE_V    = OUT_W'(WCE);
  localparam logic [PI_W-1:0]  PI_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state;
  logic [SC_W-1:0]   settle_cnt;

  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [OUT_W-1:0]  exact;
  logic [OUT_W-1:0]  err;
  logic              is_err;
  logic              is_viol;
  logic [CNT_W-1:0]  viol_next;

  // Grading datapath for the vector currently on pi; only consumed in S_CHECK.
  always_comb begin
    op_a      = pi[OP_W-1:0];
    op_b      = pi[PI_W-1:OP_W];
    exact     = OUT_W'(op_a) + OUT_W'(op_b);
    err       = (exact >= po) ? (exact - po) : (po - exact);
    is_err    = (err != '0);
    is_viol   = (err > WCE_V);
    viol_next = viol_cnt + CNT_W'(is_viol);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      pi         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      max_err    <= '0;
      err_cnt    <= '0;
      viol_cnt   <= '0;
      first_viol <= '0;
    end else if (abort) begin
      // Statistics survive an abort so they can still be inspected.
      state      <= S_IDLE;
      settle_cnt <= '0;
      pi         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_V;
            pi         <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            max_err    <= '0;
            err_cnt    <= '0;
            viol_cnt   <= '0;
            first_viol <= '0;
          end
        end

        S_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SC_W'(1)) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (err > max_err) begin
            max_err <= err;
          end
          err_cnt  <= err_cnt + CNT_W'(is_err);
          viol_cnt <= viol_next;
          if (is_viol && (viol_cnt == '0)) begin
            first_viol <= pi;
          end
          // The all-ones vector ends the sweep; pi never wraps back to zero.
          if (pi == PI_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (viol_next == '0);
          end else begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_V;
            pi         <= pi + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_sweep_ctrl.sv
// tb/tb_approx_adder_sweep_ctrl.sv - sweep controller bench with timeline model of two SETTLE variants
module tb_approx_adder_sweep_ctrl;

  localparam int NV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort;

  logic [3:0] pi0, pi1, fv0, fv1;
  logic [2:0] po0, po1, mx0, mx1;
  logic [4:0] ec0, ec1, vc0, vc1;
  logic       busy0, busy1, done0, done1, pass0, pass1;

  approx_adder_sweep_ctrl #(.OP_W(2), .OUT_W(3), .WCE(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi(pi0), .po(po0),
    .busy(busy0), .done(done0), .pass(pass0), .max_err(mx0), .err_cnt(ec0),
    .viol_cnt(vc0), .first_viol(fv0)
  );

  approx_adder_sweep_ctrl #(.OP_W(2), .OUT_W(3), .WCE(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi(pi1), .po(po1),
    .busy(busy1), .done(done1), .pass(pass1), .max_err(mx1), .err_cnt(ec1),
    .viol_cnt(vc1), .first_viol(fv1)
  );

  int         mode;
  logic [2:0] lut [NV];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         chk_on = 1'b0;

  int m_run [2], m_done [2], m_e [2], m_k [2], m_start [2];
  int e_pi [2], e_max [2], e_err [2], e_viol [2], e_fv [2];

  function automatic int model_po(input int md, input int v);
    int s;
    s = (v % 4) + (v / 4);
    case (md)
      0:       return s;
      1:       return s & ~1;
      2:       return 0;
      default: return int'(lut[v]);
    endcase
  endfunction

  // Statistics of the first k vectors of the current adder model.
  task automatic prefix(input int k, output int mx, output int ec, output int vc, output int fv);
    int ex, p, er;
    mx = 0; ec = 0; vc = 0; fv = 0;
    for (int v = 0; v < k; v++) begin
      ex = (v % 4) + (v / 4);
      p  = model_po(mode, v);
      er = (ex > p) ? ex - p : p - ex;
      if (er > mx) mx = er;
      if (er != 0) ec++;
      if (er > 2) begin
        if (vc == 0) fv = v;
        vc++;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Adder under test responds half a cycle after pi moves; still well inside every settle window.
  always @(negedge clk) begin
    po0 = 3'(model_po(mode, int'(pi0)));
    po1 = 3'(model_po(mode, int'(pi1)));
  end

  // Timeline model: a sweep of S settle cycles per vector has finished k = elapsed/(S+1) vectors.
  always @(posedge clk) begin
    int per;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      per = (d == 0) ? 2 : 4;
      if (!rst_n) begin
        m_run[d] = 0; m_done[d] = 0; m_k[d] = 0; m_e[d] = 0; e_pi[d] = 0;
        prefix(0, e_max[d], e_err[d], e_viol[d], e_fv[d]);
      end else if (abort) begin
        m_run[d] = 0; m_done[d] = 0; e_pi[d] = 0;
      end else if (start && m_run[d] == 0) begin
        m_run[d] = 1; m_done[d] = 0; m_e[d] = 0; m_k[d] = 0; m_start[d] = cyc; e_pi[d] = 0;
        prefix(0, e_max[d], e_err[d], e_viol[d], e_fv[d]);
      end else if (m_run[d] != 0) begin
        m_e[d]++;
        m_k[d] = m_e[d] / per;
        if (m_k[d] == NV) begin
          m_run[d] = 0; m_done[d] = 1; e_pi[d] = NV - 1;
        end else begin
          e_pi[d] = m_k[d];
        end
        prefix(m_k[d], e_max[d], e_err[d], e_viol[d], e_fv[d]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pi[%0d]", d),   int'(d == 0 ? pi0 : pi1), e_pi[d]);
        chk($sformatf("busy[%0d]", d), int'(d == 0 ? busy0 : busy1), m_run[d]);
        chk($sformatf("done[%0d]", d), int'(d == 0 ? done0 : done1), m_done[d]);
        chk($sformatf("max_err[%0d]", d), int'(d == 0 ? mx0 : mx1), e_max[d]);
        chk($sformatf("err_cnt[%0d]", d), int'(d == 0 ? ec0 : ec1), e_err[d]);
        chk($sformatf("viol_cnt[%0d]", d), int'(d == 0 ? vc0 : vc1), e_viol[d]);
        if (e_viol[d] != 0)
          chk($sformatf("first_viol[%0d]", d), int'(d == 0 ? fv0 : fv1), e_fv[d]);
        if (m_done[d] != 0)
          chk($sformatf("pass[%0d]", d), int'(d == 0 ? pass0 : pass1), (e_viol[d] == 0) ? 1 : 0);
        else if (m_run[d] == 0)
          chk($sformatf("pass_idle[%0d]", d), int'(d == 0 ? pass0 : pass1), 0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic wait_both(input bit chk_lat);
    bit seen0, seen1;
    int budget;
    seen0 = 0; seen1 = 0; budget = 300;
    while (!(seen0 && seen1) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (done0 && !seen0) begin
        seen0 = 1;
        if (chk_lat) chk("latency[0]", cyc - m_start[0], 32);
      end
      if (done1 && !seen1) begin
        seen1 = 1;
        if (chk_lat) chk("latency[1]", cyc - m_start[1], 64);
      end
    end
    if (budget == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic lit(input int mx, input int ec, input int vc, input int ps, input int fv);
    chk("lit_max_err", int'(mx0), mx);
    chk("lit_err_cnt", int'(ec0), ec);
    chk("lit_viol_cnt", int'(vc0), vc);
    chk("lit_pass", int'(pass0), ps);
    if (vc != 0) chk("lit_first_viol", int'(fv0), fv);
    chk("lit3_err_cnt", int'(ec1), ec);
    chk("lit3_pass", int'(pass1), ps);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    for (int v = 0; v < NV; v++) lut[v] = 3'd0;
    @(posedge clk); #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pi", int'(pi0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);

    // Exact adder, with latency pinned for both settle lengths.
    mode = 0; pulse_start(); wait_both(1'b1);
    lit(0, 0, 0, 1, 0);

    // Low bit dropped.
    mode = 1; pulse_start(); wait_both(1'b1);
    lit(1, 8, 0, 1, 0);

    // Output stuck at zero.
    mode = 2; pulse_start(); wait_both(1'b1);
    lit(6, 15, 10, 0, 3);

    // Abort ten cycles in, then a clean restart.
    mode = 0; pulse_start();
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_pi", int'(pi0), 0);
    pulse_start(); wait_both(1'b1);
    lit(0, 0, 0, 1, 0);

    // A second start while busy must not restart the sweep.
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_both(1'b1);

    // Reset mid-sweep after a violation has been latched.
    mode = 2; pulse_start();
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pi", int'(pi0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_max_err", int'(mx0), 0);
    chk("rst_err_cnt", int'(ec0), 0);
    chk("rst_viol_cnt", int'(vc0), 0);
    chk("rst_first_viol", int'(fv0), 0);

    // Abort and start together: abort wins.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", int'(busy0), 0);

    // Random adder tables with random aborts and stray start pulses.
    for (int it = 0; it < 8; it++) begin
      mode = 3;
      for (int v = 0; v < NV; v++) lut[v] = 3'($urandom_range(0, 7));
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 70)) @(posedge clk);
        pulse_abort();
      end else begin
        wait_both(1'b0);
      end
      repeat (3) @(posedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
